// File: rtl/round_scorer.sv
// Round controller for a two-player code game: runs a timed round, counts strikes
// from player2 verdicts and accumulates a saturating score from seconds left on a win.
module round_scorer #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int ROUND_SECONDS = 60,
   parameter int MAX_STRIKES   = 3
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic [9:0] p1_value,
   input  logic [1:0] correct,
   input  logic       complete,
   output logic [1:0] state,
   output logic [7:0] score,
   output logic [1:0] strikes,
   output logic [7:0] time_left,
   output logic       round_win,
   output logic       round_lose,
   output logic       p2_clear
);

   localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
   localparam logic [7:0] ROUND_SECS = 8'(ROUND_SECONDS);
   localparam logic [1:0] MAX_STR    = 2'(MAX_STRIKES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_WIN  = 2'b10,
      ST_LOSE = 2'b11
   } state_e;

   state_e               state_q, state_d;
   logic [7:0]           score_q, score_d;
   logic [1:0]           strikes_q, strikes_d;
   logic [7:0]           time_left_q, time_left_d;
   logic                 round_win_q, round_win_d;
   logic                 round_lose_q, round_lose_d;
   logic                 p2_clear_q, p2_clear_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [1:0]           settle_q, settle_d;
   logic                 complete_q, complete_d;

   logic                 wrap, settled, win_ev, strike_ev, tout_ev;
   logic [1:0]           strikes_inc;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      strikes_d    = strikes_q;
      time_left_d  = time_left_q;
      presc_d      = presc_q;
      settle_d     = settle_q;
      round_win_d  = 1'b0;
      round_lose_d = 1'b0;
      p2_clear_d   = 1'b0;
      complete_d   = complete;

      wrap        = (presc_q == PRESC_MAX);
      settled     = (settle_q == 2'd0);
      win_ev      = settled && complete_q && (p1_value != 10'd0);
      strike_ev   = settled && (correct == 2'b10);
      tout_ev     = wrap && (time_left_q == 8'd1);
      strikes_inc = strikes_q + 2'd1;

      case (state_q)
         ST_PLAY: begin
            presc_d = wrap ? '0 : presc_q + 1'b1;
            if (!settled) settle_d = settle_q - 2'd1;
            // Last second is never decremented here; the timeout event zeroes it instead,
            // so a strike that pre-empts the timeout leaves the round still armed to expire.
            if (wrap && (time_left_q > 8'd1)) time_left_d = time_left_q - 8'd1;

            if (win_ev) begin
               state_d     = ST_WIN;
               score_d     = sat_add8(score_q, time_left_q);
               round_win_d = 1'b1;
            end else if (strike_ev) begin
               strikes_d = strikes_inc;
               if (strikes_inc == MAX_STR) begin
                  state_d      = ST_LOSE;
                  round_lose_d = 1'b1;
               end
            end else if (tout_ev) begin
               time_left_d  = 8'd0;
               state_d      = ST_LOSE;
               round_lose_d = 1'b1;
            end
         end
         default: begin
            if (start) begin
               state_d     = ST_PLAY;
               time_left_d = ROUND_SECS;
               strikes_d   = 2'd0;
               presc_d     = '0;
               settle_d    = 2'd2;
               p2_clear_d  = 1'b1;
               if (state_q == ST_LOSE) score_d = 8'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (resetn) begin
         state_q      <= ST_IDLE;
         score_q      <= 8'd0;
         strikes_q    <= 2'd0;
         time_left_q  <= 8'd0;
         round_win_q  <= 1'b0;
         round_lose_q <= 1'b0;
         p2_clear_q   <= 1'b0;
         presc_q      <= '0;
         settle_q     <= 2'd0;
         complete_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         score_q      <= score_d;
         strikes_q    <= strikes_d;
         time_left_q  <= time_left_d;
         round_win_q  <= round_win_d;
         round_lose_q <= round_lose_d;
         p2_clear_q   <= p2_clear_d;
         presc_q      <= presc_d;
         settle_q     <= settle_d;
         complete_q   <= complete_d;
      end
   end

   assign state      = state_q;
   assign score      = score_q;
   assign strikes    = strikes_q;
   assign time_left  = time_left_q;
   assign round_win  = round_win_q;
   assign round_lose = round_lose_q;
   assign p2_clear   = p2_clear_q;

endmodule

// File: doc/round_scorer.md
ROUND_SCORER -- requirements
Module: round_scorer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, clock cycles per game second.
REQ-002 SHALL have parameter ROUND_SECONDS, default 60, round length in seconds (1..255).
REQ-003 SHALL have parameter MAX_STRIKES, default 3, incorrect inputs that end a round (1..3).
REQ-004 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn  in  1  synchronous, active-high reset (despite the name).
REQ-006 SHALL have port start  in  1  level sampled each cycle; begins a round when honoured.
REQ-007 SHALL have port p1_value  in  10  player1 code; 0 means no code set.
REQ-008 SHALL have port correct  in  2  player2 verdict: 00 neutral, 01 correct, 10 incorrect, 11 treated as neutral.
REQ-009 SHALL have port complete  in  1  player2 code-match flag.
REQ-010 SHALL have port state  out  2  IDLE=00, PLAY=01, WIN=10, LOSE=11.
REQ-011 SHALL have port score  out  8  cumulative score.
REQ-012 SHALL have port strikes  out  2  incorrect count this round.
REQ-013 SHALL have port time_left  out  8  seconds remaining.
REQ-014 SHALL have port round_win  out  1  one-cycle pulse on entry to WIN.
REQ-015 SHALL have port round_lose  out  1  one-cycle pulse on entry to LOSE.
REQ-016 SHALL have port p2_clear  out  1  one-cycle pulse, drives player2 resetn.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 complete SHALL be captured into a register complete_q each cycle; only complete_q is used for decisions.
REQ-019 IDLE/WIN/LOSE with start=1 SHALL go to PLAY next cycle: time_left=ROUND_SECONDS, strikes=0, prescaler=0, settle=2, p2_clear=1 for that one cycle.
REQ-020 Start from LOSE SHALL also clear score to 0; start from IDLE or WIN SHALL keep score.
REQ-021 In PLAY, while settle>0, settle SHALL decrement each cycle and correct/complete_q SHALL be ignored; prescaler and timer still run.
REQ-022 In PLAY, prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; on each wrap time_left SHALL decrement by 1.
REQ-023 Win condition: settle==0, complete_q==1, p1_value!=0.
REQ-024 Strike condition: settle==0, correct==10.
REQ-025 Timeout condition: prescaler wrap with time_left==1.
REQ-026 Priority per cycle in PLAY SHALL be win > strike > timeout; only the highest-priority event takes effect.
REQ-027 Win SHALL move to WIN next cycle, score=min(255, score+time_left) using time_left before any same-cycle decrement, round_win=1 for one cycle.
REQ-028 Strike SHALL increment strikes; if the new value equals MAX_STRIKES, SHALL move to LOSE with round_lose=1 for one cycle.
REQ-029 Timeout SHALL set time_left=0 and move to LOSE with round_lose=1 for one cycle.
REQ-030 correct==01 SHALL have no effect on any output.
REQ-031 In WIN/LOSE, time_left, strikes and score SHALL hold until start.
REQ-032 start held high SHALL be honoured only from IDLE/WIN/LOSE; it is ignored during PLAY.

Reset
REQ-033 resetn=1 SHALL, at the next edge and with priority over all inputs, force state=IDLE, score=0, strikes=0, time_left=0, round_win=0, round_lose=0, p2_clear=0, prescaler=0, settle=0, complete_q=0.
REQ-034 Reset during PLAY SHALL abort the round with no round_win/round_lose pulse.

Verification (TICKS_PER_SEC=4, ROUND_SECONDS=3, MAX_STRIKES=3)
REQ-035 Reset 2 cycles -> state=00, score=0, strikes=0, time_left=0, all pulses 0.
REQ-036 start 1 cycle, p1_value=10'b0101000000, complete=1 from cycle 3 of PLAY -> p2_clear on cycle 1, WIN, round_win 1 cycle, score=3.
REQ-037 start, then correct=10 on three non-settle cycles -> strikes 1,2,3, LOSE after third, round_lose 1 cycle.
REQ-038 start, no input -> time_left 3,2,1,0 at 4-cycle intervals, LOSE on the 12th PLAY cycle, round_lose pulse.
REQ-039 complete_q=1 and correct=10 same cycle -> WIN, strikes unchanged; complete=1 with p1_value=0 -> stays PLAY.
REQ-040 score=254 then win with time_left=3 -> score=255; then reset mid-PLAY -> IDLE, score=0, no pulses.
